jpegls_mode_determination: RTL and testbench

- Per-pixel coding-mode selector for the JPEG-LS lossless encoder (NEAR = 0).
- Sits between the causal-neighbour fetch stage and the regular/run coding paths.
- From neighbours a (Ra), b (Rb), c (Rc), d (Rd), the current sample x and an end-of-line flag, it decides whether the pixel is regular-coded, continues a run, interrupts a run, or ends a run at line end.
- It holds the run state (in-run flag and run value) across pixels.

---
 rtl/jpegls_mode_determination_if.sv | 26 ++
 rtl/jpegls_mode_determination.sv | 90 +++++++++
 tb/tb_jpegls_mode_determination.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/jpegls_mode_determination_if.sv
// Pixel bus between the neighbour-fetch stage and the mode selector.
// The fetch stage drives the pixel and its causal context; the selector
// returns the coding mode for that pixel in the same cycle.
interface jpegls_mode_determination_if #(
    parameter int pixel_length = 8,
    parameter int mode_length  = 2
);
    logic                    start_enc;
    logic [pixel_length-1:0] a;
    logic [pixel_length-1:0] b;
    logic [pixel_length-1:0] c;
    logic [pixel_length-1:0] d;
    logic [pixel_length-1:0] x;
    logic                    EOL;
    logic [mode_length-1:0]  mode;

    modport master (
        output start_enc, a, b, c, d, x, EOL,
        input  mode
    );

    modport slave (
        input  start_enc, a, b, c, d, x, EOL,
        output mode
    );
endinterface

// File: rtl/jpegls_mode_determination.sv
// JPEG-LS (NEAR = 0) per-pixel coding-mode selector.
// Mode is combinational from the current pixel and the held run state;
// the run state advances on each enabled clock edge.
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_CONTEXT  | not in a run; a flat context (a=b=c=d) starts run detection
// ST_RUN      | run in progress; x is compared against the held run value
module jpegls_mode_determination #(
    parameter int pixel_length = 8,
    parameter int mode_length  = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    jpegls_mode_determination_if.slave    bus
);

    localparam logic [mode_length-1:0] MODE_REGULAR   = mode_length'(0);
    localparam logic [mode_length-1:0] MODE_RUN       = mode_length'(1);
    localparam logic [mode_length-1:0] MODE_RUN_INTR  = mode_length'(2);
    localparam logic [mode_length-1:0] MODE_RUN_EOL   = mode_length'(3);

    typedef enum logic {
        ST_CONTEXT = 1'b0,
        ST_RUN     = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [pixel_length-1:0] r_run_val;
    logic [mode_length-1:0]  w_mode;
    logic [pixel_length-1:0] w_ref;
    logic                    w_flat;
    logic                    w_enter_run;

    // Local gradients with one extra sign bit; flat means all three are zero.
    logic [pixel_length:0]   w_d1;
    logic [pixel_length:0]   w_d2;
    logic [pixel_length:0]   w_d3;

    assign w_d1   = {1'b0, bus.d} - {1'b0, bus.b};
    assign w_d2   = {1'b0, bus.b} - {1'b0, bus.c};
    assign w_d3   = {1'b0, bus.c} - {1'b0, bus.a};
    assign w_flat = (w_d1 == '0) && (w_d2 == '0) && (w_d3 == '0);

    // A run value is captured only when a run is being entered from context.
    assign w_enter_run = bus.start_enc && (r_state == ST_CONTEXT) && w_flat;

    // Run state register; reset drops any run in progress immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_CONTEXT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Run value register; holds through the run and across idle cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_run_val <= '0;
        end else if (w_enter_run) begin
            r_run_val <= bus.a;
        end
    end

    // Mode decision and next run state; mode is forced to REGULAR when idle or in reset.
    always_comb begin
        w_state_next = r_state;
        w_mode       = MODE_REGULAR;
        w_ref        = bus.a;
        if (reset && bus.start_enc) begin
            if ((r_state == ST_RUN) || w_flat) begin
                w_ref = (r_state == ST_RUN) ? r_run_val : bus.a;
                if (bus.x != w_ref) begin
                    w_mode = MODE_RUN_INTR;
                end else if (bus.EOL) begin
                    w_mode = MODE_RUN_EOL;
                end else begin
                    w_mode = MODE_RUN;
                end
            end
            // Interrupt and end-of-line both close the run; only a plain RUN keeps it.
            w_state_next = (w_mode == MODE_RUN) ? ST_RUN : ST_CONTEXT;
        end
    end

    assign bus.mode = w_mode;

endmodule

// File: tb/tb_jpegls_mode_determination.sv
// Self-checking bench for jpegls_mode_determination: a directed vector table,
// hand-written reset/run sequences and randomized pixels against a model.
module tb_jpegls_mode_determination;

    logic clk;
    logic reset;

    jpegls_mode_determination_if #(.pixel_length(8), .mode_length(2)) bus_if ();

    jpegls_mode_determination #(.pixel_length(8), .mode_length(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic [7:0] a, b, c, d, x;
        logic       eol;
        logic [1:0] exp_mode;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    // Reference model state, kept as plain variables.
    bit      m_in_run;
    int      m_run_val;

    task automatic drive(input logic st, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d, input logic [7:0] x,
                         input logic eol);
        bus_if.start_enc = st;
        bus_if.a = a;
        bus_if.b = b;
        bus_if.c = c;
        bus_if.d = d;
        bus_if.x = x;
        bus_if.EOL = eol;
    endtask

    task automatic check_mode(input string name, input logic [1:0] exp_mode);
        checks++;
        if (bus_if.mode !== exp_mode) begin
            failures++;
            $display("FAIL %s: mode got %0d expected %0d", name, bus_if.mode, exp_mode);
        end
    endtask

    // Drive one pixel just after a rising edge and check at the falling edge.
    task automatic apply_pixel(input string name, input vec_t v);
        @(posedge clk);
        #1;
        drive(v.start, v.a, v.b, v.c, v.d, v.x, v.eol);
        @(negedge clk);
        check_mode(name, v.exp_mode);
    endtask

    // Behavioural reference: what the coder should pick for this pixel.
    function automatic int model_mode(input bit st, input int a, input int b, input int c,
                                      input int d, input int x, input bit eol);
        bit flat;
        int r;
        if (!st) return 0;
        flat = (a == b) && (b == c) && (c == d);
        if (!m_in_run && !flat) return 0;
        r = m_in_run ? m_run_val : a;
        if (x != r) return 2;
        return eol ? 3 : 1;
    endfunction

    vec_t tbl[18];

    initial begin
        tbl[0]  = '{1'b0,  8'd10,  8'd20,  8'd15,  8'd30,  8'd12, 1'b0, 2'd0};
        tbl[1]  = '{1'b1,  8'd10,  8'd20,  8'd15,  8'd30,  8'd12, 1'b0, 2'd0};
        tbl[2]  = '{1'b1,  8'd1,   8'd2,   8'd3,   8'd4,   8'd9,  1'b0, 2'd0};
        tbl[3]  = '{1'b1,  8'd50,  8'd50,  8'd50,  8'd50,  8'd50, 1'b0, 2'd1};
        tbl[4]  = '{1'b1,  8'd50,  8'd7,   8'd9,   8'd3,   8'd50, 1'b0, 2'd1};
        tbl[5]  = '{1'b0,  8'd1,   8'd1,   8'd1,   8'd1,   8'd2,  1'b1, 2'd0};
        tbl[6]  = '{1'b1,  8'd1,   8'd2,   8'd3,   8'd4,   8'd50, 1'b0, 2'd1};
        tbl[7]  = '{1'b1,  8'd1,   8'd2,   8'd3,   8'd4,   8'd51, 1'b0, 2'd2};
        tbl[8]  = '{1'b1,  8'd1,   8'd2,   8'd3,   8'd4,   8'd1,  1'b0, 2'd0};
        tbl[9]  = '{1'b1,  8'd50,  8'd50,  8'd50,  8'd50,  8'd50, 1'b0, 2'd1};
        tbl[10] = '{1'b1,  8'd9,   8'd8,   8'd7,   8'd6,   8'd50, 1'b1, 2'd3};
        tbl[11] = '{1'b1,  8'd1,   8'd2,   8'd3,   8'd4,   8'd1,  1'b0, 2'd0};
        tbl[12] = '{1'b1,  8'd255, 8'd255, 8'd255, 8'd255, 8'd0,  1'b1, 2'd2};
        tbl[13] = '{1'b1,  8'd1,   8'd2,   8'd3,   8'd4,   8'd255,1'b0, 2'd0};
        tbl[14] = '{1'b1,  8'd0,   8'd0,   8'd0,   8'd0,   8'd0,  1'b1, 2'd3};
        tbl[15] = '{1'b1,  8'd0,   8'd1,   8'd0,   8'd0,   8'd0,  1'b0, 2'd0};
        tbl[16] = '{1'b1,  8'd255, 8'd255, 8'd255, 8'd255, 8'd255,1'b0, 2'd1};
        tbl[17] = '{1'b1,  8'd0,   8'd3,   8'd0,   8'd0,   8'd255,1'b0, 2'd1};
    end

    initial begin
        vec_t v;
        int   a, b, c, d, x, exp_m;
        bit   st, eol, flat;

        drive(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        reset = 1'b0;
        #12;
        check_mode("reset_idle", 2'd0);
        // Even a valid matching flat pixel must show REGULAR while in reset.
        drive(1'b1, 8'd50, 8'd50, 8'd50, 8'd50, 8'd50, 1'b0);
        #1;
        check_mode("reset_flat_masked", 2'd0);
        @(negedge clk);
        drive(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        reset = 1'b1;
        #1;
        check_mode("after_reset_idle", 2'd0);

        for (int i = 0; i < 18; i++) begin
            apply_pixel($sformatf("table_%0d", i), tbl[i]);
        end

        // Reset mid-run: run (val 255) is dropped and mode clears at once.
        v = '{1'b1, 8'd0, 8'd1, 8'd2, 8'd3, 8'd255, 1'b0, 2'd1};
        apply_pixel("pre_reset_run", v);
        #1;
        reset = 1'b0;
        #1;
        check_mode("reset_mid_run", 2'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        v = '{1'b1, 8'd0, 8'd1, 8'd2, 8'd3, 8'd255, 1'b0, 2'd0};
        apply_pixel("post_reset_context", v);
        v = '{1'b1, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 1'b0, 2'd1};
        apply_pixel("restart_from_a", v);
        // In a run, a different flat context is compared against the run value, not a.
        v = '{1'b1, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 1'b0, 2'd2};
        apply_pixel("run_ref_not_a", v);
        v = '{1'b1, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 1'b0, 2'd1};
        apply_pixel("new_run_from_a", v);
        v = '{1'b1, 8'd1, 8'd2, 8'd3, 8'd4, 8'd9, 1'b0, 2'd1};
        apply_pixel("run_val_captured", v);

        // Randomized pixels against the model, starting from a clean reset.
        @(negedge clk);
        drive(1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        m_in_run  = 1'b0;
        m_run_val = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            st  = ($urandom_range(0, 7) != 0);
            eol = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) begin
                a = $urandom_range(0, 255); b = $urandom_range(0, 255);
                c = $urandom_range(0, 255); d = $urandom_range(0, 255);
                x = $urandom_range(0, 255);
            end else begin
                a = $urandom_range(0, 1) ? 255 : $urandom_range(0, 1);
                b = ($urandom_range(0, 3) != 0) ? a : $urandom_range(0, 1);
                c = ($urandom_range(0, 3) != 0) ? a : $urandom_range(0, 1);
                d = ($urandom_range(0, 3) != 0) ? a : $urandom_range(0, 1);
                x = ($urandom_range(0, 3) != 0) ? (m_in_run ? m_run_val : a)
                                                 : $urandom_range(0, 255);
            end
            drive(st, 8'(a), 8'(b), 8'(c), 8'(d), 8'(x), eol);
            exp_m = model_mode(st, a, b, c, d, x, eol);
            @(negedge clk);
            check_mode($sformatf("random_%0d", i), 2'(exp_m));
            if (st) begin
                flat = (a == b) && (b == c) && (c == d);
                if (!m_in_run && flat) m_run_val = a;
                m_in_run = (exp_m == 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
